// File: rtl/ternary_operand_collector.sv
// Packs a valid/ready word stream into operand triples for a 3-input adder.
// The registered sum is returned on a valid/ready result port with the real operand count.
module ternary_operand_collector #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic [W-1:0] add_c,
  input  logic [W-1:0] add_q,
  output logic [W-1:0] res_data,
  output logic [1:0]   res_n,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy
);

  // Handshakes: a word moves when in_valid && in_ready at a rising edge; a result
  // moves when res_valid && res_ready. Data is held stable while valid && !ready.

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] EVAL    = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [2:0][W-1:0]   slot_q, slot_d;
  logic [1:0]          size_q, size_d;
  logic [W-1:0]        res_data_q, res_data_d;
  logic [1:0]          res_n_q, res_n_d;
  logic                res_valid_q, res_valid_d;

  logic collect;
  logic accept;
  logic flush_close;

  always_comb begin
    collect     = (state_q == COLLECT);
    // Any word that would close a group must wait for the result slot to drain.
    in_ready    = collect && !(res_valid_q && ((cnt_q == 2'd2) || flush));
    accept      = in_valid && in_ready;
    flush_close = collect && flush && !accept && (cnt_q != 2'd0) && !res_valid_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    size_d      = size_q;
    res_data_d  = res_data_q;
    res_n_d     = res_n_q;
    res_valid_d = res_valid_q;

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    if (state_q == EVAL) begin
      res_data_d  = add_q;
      res_n_d     = size_q;
      res_valid_d = 1'b1;
      state_d     = COLLECT;
    end else if (accept) begin
      // Starting a group clears every slot, so unwritten slots of a short group read zero.
      if (cnt_q == 2'd0) begin
        slot_d = '0;
      end
      slot_d[cnt_q] = in_data;
      if ((cnt_q == 2'd2) || flush) begin
        size_d  = cnt_q + 2'd1;
        cnt_d   = 2'd0;
        state_d = EVAL;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else if (flush_close) begin
      size_d  = cnt_q;
      cnt_d   = 2'd0;
      state_d = EVAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= 2'd0;
      slot_q      <= '0;
      size_q      <= 2'd0;
      res_data_q  <= '0;
      res_n_q     <= 2'd0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      size_q      <= size_d;
      res_data_q  <= res_data_d;
      res_n_q     <= res_n_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign add_a     = slot_q[0];
  assign add_b     = slot_q[1];
  assign add_c     = slot_q[2];
  assign res_data  = res_data_q;
  assign res_n     = res_n_q;
  assign res_valid = res_valid_q;
  assign busy      = (cnt_q != 2'd0) || (state_q == EVAL) || res_valid_q;

endmodule

// File: tb/tb_ternary_operand_collector.sv
// Directed bench for ternary_operand_collector: vector table plus hand-written corner sequences.
// The adder is modelled here as a combinational modulo-2^W sum.
module tb_ternary_operand_collector;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] add_a, add_b, add_c, add_q;
  logic [W-1:0] res_data;
  logic [1:0]   res_n;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  int checks = 0;
  int failures = 0;
  int waits;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;

  typedef struct {
    logic [W-1:0] a, b, c;
    int           n;
    logic [W-1:0] s;
    logic [1:0]   rn;
  } vec_t;
  vec_t vecs[6];

  ternary_operand_collector #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_q(add_q),
    .res_data(res_data), .res_n(res_n), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy)
  );

  assign add_q = add_a + add_b + add_c;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every result handshake is compared with the oldest expected {n, sum}.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got data=%0d n=%0d expected none", res_data, res_n);
      end else begin
        mon_e = exp_q.pop_front();
        chk("res_data", 32'(res_data), 32'(mon_e[W-1:0]));
        chk("res_n", 32'(res_n), 32'(mon_e[W+1:W]));
      end
    end
  end

  task automatic push_exp(input logic [1:0] n, input logic [W-1:0] s);
    exp_q.push_back({n, s});
  endtask

  // Offer one word (optionally with flush); returns 1 ns after the accepting edge.
  task automatic send(input logic [W-1:0] d, input logic fl, output int nwait);
    nwait = 0;
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    flush    = fl;
    #1;
    while (!in_ready) begin
      nwait++;
      if (nwait > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready got 0 expected 1 for word %0d", d);
        break;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{a: 5'd31, b: 5'd31, c: 5'd31, n: 3, s: 5'd29, rn: 2'd3};
    vecs[1] = '{a: 5'd16, b: 5'd16, c: 5'd1,  n: 3, s: 5'd1,  rn: 2'd3};
    vecs[2] = '{a: 5'd7,  b: 5'd0,  c: 5'd0,  n: 1, s: 5'd7,  rn: 2'd1};
    vecs[3] = '{a: 5'd5,  b: 5'd6,  c: 5'd0,  n: 2, s: 5'd11, rn: 2'd2};
    vecs[4] = '{a: 5'd0,  b: 5'd0,  c: 5'd0,  n: 3, s: 5'd0,  rn: 2'd3};
    vecs[5] = '{a: 5'd20, b: 5'd15, c: 5'd0,  n: 2, s: 5'd3,  rn: 2'd2};

    rst = 1'b1; in_data = '0; in_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 3,4,5: EVAL one cycle after the third accept, result visible one edge later for one cycle.
    push_exp(2'd3, 5'd12);
    send(5'd3, 1'b0, waits);
    send(5'd4, 1'b0, waits);
    send(5'd5, 1'b0, waits);
    chk("eval_res_valid", 32'(res_valid), 32'd0);
    chk("eval_busy", 32'(busy), 32'd1);
    chk("eval_add_a", 32'(add_a), 32'd3);
    chk("eval_add_b", 32'(add_b), 32'd4);
    chk("eval_add_c", 32'(add_c), 32'd5);
    @(posedge clk); #1;
    chk("lat_res_valid", 32'(res_valid), 32'd1);
    chk("lat_res_data", 32'(res_data), 32'd12);
    @(posedge clk); #1;
    chk("pulse_res_valid", 32'(res_valid), 32'd0);
    wait_drain();

    // Table: short groups are closed by a flush-only cycle.
    for (int i = 0; i < 6; i++) begin
      push_exp(vecs[i].rn, vecs[i].s);
      send(vecs[i].a, 1'b0, waits);
      if (vecs[i].n > 1) send(vecs[i].b, 1'b0, waits);
      if (vecs[i].n > 2) send(vecs[i].c, 1'b0, waits);
      else flush_pulse();
      wait_drain();
    end

    // Flush-only close: EVAL sees 7,0,0; a later flush at cnt==0 produces nothing.
    push_exp(2'd1, 5'd7);
    send(5'd7, 1'b0, waits);
    flush_pulse();
    chk("fl_add_a", 32'(add_a), 32'd7);
    chk("fl_add_b", 32'(add_b), 32'd0);
    chk("fl_add_c", 32'(add_c), 32'd0);
    wait_drain();
    flush_pulse();
    repeat (3) @(posedge clk);
    #1;
    chk("fl0_busy", 32'(busy), 32'd0);
    chk("fl0_res_valid", 32'(res_valid), 32'd0);

    // Back-pressure: words 4,5 accepted while a result waits, word 6 held off.
    res_ready = 1'b0;
    push_exp(2'd3, 5'd6);
    push_exp(2'd3, 5'd15);
    send(5'd1, 1'b0, waits);
    send(5'd2, 1'b0, waits);
    send(5'd3, 1'b0, waits);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_res_valid", 32'(res_valid), 32'd1);
    send(5'd4, 1'b0, waits);
    chk("bp_w4_waits", 32'(waits), 32'd0);
    send(5'd5, 1'b0, waits);
    chk("bp_w5_waits", 32'(waits), 32'd0);
    @(negedge clk);
    in_data = 5'd6; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(res_data), 32'd6);
      chk("bp_hold_valid", 32'(res_valid), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    send(5'd6, 1'b0, waits);
    wait_drain();

    // Word with flush in one cycle closes a 1-word group; next group has no stale operand.
    push_exp(2'd1, 5'd9);
    push_exp(2'd3, 5'd3);
    send(5'd9, 1'b1, waits);
    chk("wf_add_b", 32'(add_b), 32'd0);
    send(5'd1, 1'b0, waits);
    send(5'd1, 1'b0, waits);
    send(5'd1, 1'b0, waits);
    wait_drain();

    // Reset with two words collected and a result pending discards everything.
    res_ready = 1'b0;
    send(5'd1, 1'b0, waits);
    send(5'd2, 1'b0, waits);
    send(5'd3, 1'b0, waits);
    repeat (2) @(posedge clk);
    send(5'd4, 1'b0, waits);
    send(5'd5, 1'b0, waits);
    rst = 1'b1;
    #1;
    chk("mr_res_valid", 32'(res_valid), 32'd0);
    chk("mr_res_data", 32'(res_data), 32'd0);
    chk("mr_res_n", 32'(res_n), 32'd0);
    chk("mr_add_a", 32'(add_a), 32'd0);
    chk("mr_add_b", 32'(add_b), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    push_exp(2'd3, 5'd6);
    send(5'd2, 1'b0, waits);
    send(5'd2, 1'b0, waits);
    send(5'd2, 1'b0, waits);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
